// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - monitor that decodes a scanned 8-digit 7-segment bus into A, B and result
module seg_scan_decoder #(
    parameter int unsigned STABLE_CYCLES = 16,
    parameter int unsigned FRAME_TIMEOUT = 1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg,
    input  logic [7:0] an,
    output logic [2:0] a_val,
    output logic [2:0] b_val,
    output logic [2:0] res_val,
    output logic       frame_valid,
    output logic       frame_err
);

    localparam logic [15:0] STABLE_LIM  = 16'(STABLE_CYCLES);
    localparam logic [23:0] TIMEOUT_LIM = 24'(FRAME_TIMEOUT - 1);

    // Character codes: 0..4 are the digits themselves.
    localparam logic [2:0] CH_MINUS = 3'd5;
    localparam logic [2:0] CH_BLANK = 3'd6;
    localparam logic [2:0] CH_ILL   = 3'd7;

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_CHECK} state_t;

    function automatic logic [2:0] decode_char(input logic [6:0] s);
        case (s)
            7'b1000000: return 3'd0;
            7'b1111001: return 3'd1;
            7'b0100100: return 3'd2;
            7'b0110000: return 3'd3;
            7'b0011001: return 3'd4;
            7'b0111111: return CH_MINUS;
            7'b1111111: return CH_BLANK;
            default:    return CH_ILL;
        endcase
    endfunction

    // Returns {legal, value} for a sign/magnitude character pair.
    function automatic logic [3:0] judge(input logic [2:0] sgn, input logic [2:0] mag);
        logic [3:0] r;
        r = 4'b0000;
        if (sgn == CH_BLANK && mag <= 3'd3)
            r = {1'b1, mag};
        else if (sgn == CH_MINUS && mag >= 3'd1 && mag <= 3'd4)
            r = {1'b1, 3'd0 - mag};
        return r;
    endfunction

    logic [7:0]      an_q;
    logic [6:0]      seg_q;
    logic [2:0]      prev_idx_q, prev_idx_d;
    logic [6:0]      prev_seg_q, prev_seg_d;
    logic [15:0]     dwell_q, dwell_d;
    state_t          state_q, state_d;
    logic [5:0]      mask_q, mask_d;
    logic [5:0][2:0] slot_q, slot_d;
    logic [23:0]     timer_q, timer_d;
    logic            pend_q, pend_d;
    logic [2:0]      pend_idx_q, pend_idx_d;
    logic [2:0]      pend_code_q, pend_code_d;
    logic [2:0]      a_q, a_d, b_q, b_d, r_q, r_d;
    logic            fv_q, fv_d, fe_q, fe_d;

    logic [3:0]      low_cnt;
    logic [2:0]      dig_idx;
    logic            dig_ok;
    logic            cap;
    logic            cap_lo;
    logic [2:0]      cap_code;
    logic [3:0]      j_a, j_b, j_r;

    // Find the single low anode; anything else means no digit is selected.
    always_comb begin
        low_cnt = '0;
        dig_idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (!an_q[i]) begin
                low_cnt = low_cnt + 4'd1;
                dig_idx = 3'(i);
            end
        end
        dig_ok = (low_cnt == 4'd1);
    end

    // Dwell counter: restart on any change, capture once when it reaches the limit.
    always_comb begin
        dwell_d    = dwell_q;
        cap        = 1'b0;
        prev_idx_d = prev_idx_q;
        prev_seg_d = prev_seg_q;
        if (!dig_ok) begin
            dwell_d = '0;
        end else begin
            prev_idx_d = dig_idx;
            prev_seg_d = seg_q;
            if (dwell_q == '0 || dig_idx != prev_idx_q || seg_q != prev_seg_q) begin
                dwell_d = 16'd1;
            end else if (dwell_q != STABLE_LIM) begin
                dwell_d = dwell_q + 16'd1;
                cap     = (dwell_q + 16'd1 == STABLE_LIM);
            end
        end
    end

    assign cap_lo   = cap && (dig_idx < 3'd6);
    assign cap_code = decode_char(seg_q);
    assign j_a      = judge(slot_q[0], slot_q[1]);
    assign j_b      = judge(slot_q[2], slot_q[3]);
    assign j_r      = judge(slot_q[4], slot_q[5]);

    // Frame collection FSM: collect slots, check the full frame, handle timeout.
    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        slot_d      = slot_q;
        timer_d     = timer_q;
        pend_d      = pend_q;
        pend_idx_d  = pend_idx_q;
        pend_code_d = pend_code_q;
        a_d         = a_q;
        b_d         = b_q;
        r_d         = r_q;
        fv_d        = 1'b0;
        fe_d        = 1'b0;
        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                for (int i = 0; i < 6; i++) begin
                    if (pend_q && pend_idx_q == 3'(i)) begin
                        slot_d[i] = pend_code_q;
                        mask_d[i] = 1'b1;
                    end
                    if (cap_lo && dig_idx == 3'(i)) begin
                        slot_d[i] = cap_code;
                        mask_d[i] = 1'b1;
                    end
                end
                pend_d = 1'b0;
                if (pend_q || cap_lo)
                    state_d = S_COLLECT;
            end
            S_COLLECT: begin
                if (mask_q == 6'h3F) begin
                    state_d = S_CHECK;
                    if (cap_lo) begin
                        pend_d      = 1'b1;
                        pend_idx_d  = dig_idx;
                        pend_code_d = cap_code;
                    end
                end else if (cap_lo) begin
                    timer_d = '0;
                    for (int i = 0; i < 6; i++) begin
                        if (dig_idx == 3'(i)) begin
                            slot_d[i] = cap_code;
                            mask_d[i] = 1'b1;
                        end
                    end
                end else if (timer_q == TIMEOUT_LIM) begin
                    timer_d = '0;
                    mask_d  = '0;
                    fe_d    = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + 24'd1;
                end
            end
            S_CHECK: begin
                if (j_a[3] && j_b[3] && j_r[3]) begin
                    a_d  = j_a[2:0];
                    b_d  = j_b[2:0];
                    r_d  = j_r[2:0];
                    fv_d = 1'b1;
                end else begin
                    fe_d = 1'b1;
                end
                mask_d  = '0;
                timer_d = '0;
                state_d = S_IDLE;
                if (cap_lo) begin
                    pend_d      = 1'b1;
                    pend_idx_d  = dig_idx;
                    pend_code_d = cap_code;
                end
            end
            default: begin
                state_d = S_IDLE;
                mask_d  = '0;
            end
        endcase
    end

    // State registers; input sampling stage resets to the idle bus levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_q        <= 8'hFF;
            seg_q       <= 7'h7F;
            prev_idx_q  <= '0;
            prev_seg_q  <= '0;
            dwell_q     <= '0;
            state_q     <= S_IDLE;
            mask_q      <= '0;
            slot_q      <= '0;
            timer_q     <= '0;
            pend_q      <= 1'b0;
            pend_idx_q  <= '0;
            pend_code_q <= '0;
            a_q         <= '0;
            b_q         <= '0;
            r_q         <= '0;
            fv_q        <= 1'b0;
            fe_q        <= 1'b0;
        end else begin
            an_q        <= an;
            seg_q       <= seg;
            prev_idx_q  <= prev_idx_d;
            prev_seg_q  <= prev_seg_d;
            dwell_q     <= dwell_d;
            state_q     <= state_d;
            mask_q      <= mask_d;
            slot_q      <= slot_d;
            timer_q     <= timer_d;
            pend_q      <= pend_d;
            pend_idx_q  <= pend_idx_d;
            pend_code_q <= pend_code_d;
            a_q         <= a_d;
            b_q         <= b_d;
            r_q         <= r_d;
            fv_q        <= fv_d;
            fe_q        <= fe_d;
        end
    end

    assign a_val       = a_q;
    assign b_val       = b_q;
    assign res_val     = r_q;
    assign frame_valid = fv_q;
    assign frame_err   = fe_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - scoreboard bench for seg_scan_decoder
module tb_seg_scan_decoder;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] SM = 7'b0111111;
    localparam logic [6:0] SB = 7'b1111111;

    logic       clk;
    logic       rst_n;
    logic [6:0] seg;
    logic [7:0] an;
    logic [2:0] a_val, b_val, res_val;
    logic       frame_valid, frame_err;

    typedef struct packed {
        logic       err;
        logic [2:0] a;
        logic [2:0] b;
        logic [2:0] r;
        logic       chk_t;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   pulses = 0;
    int   t5     = 0;

    seg_scan_decoder #(.STABLE_CYCLES(16), .FRAME_TIMEOUT(200)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seg        (seg),
        .an         (an),
        .a_val      (a_val),
        .b_val      (b_val),
        .res_val    (res_val),
        .frame_valid(frame_valid),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (frame_valid || frame_err) begin
            exp_t e;
            pulses = pulses + 1;
            checks = checks + 1;
            if (frame_valid && frame_err) begin
                errors = errors + 1;
                $display("FAIL both_pulses: frame_valid=1 frame_err=1 at cycle %0d, required exclusive", cyc);
            end else if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_pulse: valid=%0b err=%0b at cycle %0d, required none", frame_valid, frame_err, cyc);
            end else begin
                e = exp_q.pop_front();
                if (frame_err != e.err || a_val != e.a || b_val != e.b || res_val != e.r) begin
                    errors = errors + 1;
                    $display("FAIL frame: got err=%0b a=%b b=%b r=%b, required err=%0b a=%b b=%b r=%b",
                             frame_err, a_val, b_val, res_val, e.err, e.a, e.b, e.r);
                end
                if (e.chk_t) begin
                    checks = checks + 1;
                    if (cyc != t5 + 19) begin
                        errors = errors + 1;
                        $display("FAIL latency: pulse at cycle %0d, required %0d", cyc, t5 + 19);
                    end
                end
            end
        end
    end

    task automatic expect_frame(input logic err, input logic [2:0] a, input logic [2:0] b,
                                input logic [2:0] r, input logic chk_t);
        exp_t e;
        e.err = err; e.a = a; e.b = b; e.r = r; e.chk_t = chk_t;
        exp_q.push_back(e);
    endtask

    task automatic show(input int idx, input logic [6:0] s, input int n);
        an  = ~(8'h01 << idx);
        seg = s;
        if (idx == 5) t5 = cyc;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        an  = 8'hFF;
        seg = SB;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic scan(input logic [6:0] d0, input logic [6:0] d1, input logic [6:0] d2,
                        input logic [6:0] d3, input logic [6:0] d4, input logic [6:0] d5);
        show(0, d0, 20); show(1, d1, 20); show(2, d2, 20);
        show(3, d3, 20); show(4, d4, 20); show(5, d5, 20);
        show(6, SB, 20); show(7, SB, 20);
        idle(5);
    endtask

    task automatic check3(input string name, input logic [2:0] a, input logic [2:0] b, input logic [2:0] r);
        checks = checks + 1;
        if (a_val != a || b_val != b || res_val != r) begin
            errors = errors + 1;
            $display("FAIL %s: got a=%b b=%b r=%b, required a=%b b=%b r=%b", name, a_val, b_val, res_val, a, b, r);
        end
    endtask

    task automatic check_pulses_low(input string name);
        checks = checks + 1;
        if (frame_valid || frame_err) begin
            errors = errors + 1;
            $display("FAIL %s: got valid=%0b err=%0b, required 0 0", name, frame_valid, frame_err);
        end
    endtask

    initial begin
        int p0;
        rst_n = 1'b0;
        an    = 8'hFF;
        seg   = SB;
        repeat (5) @(posedge clk);
        #1;
        check3("reset_values", 3'b000, 3'b000, 3'b000);
        check_pulses_low("reset_pulses");
        rst_n = 1'b1;
        idle(5);
        check3("post_reset_values", 3'b000, 3'b000, 3'b000);

        // A = +3, B = -2, result = +1; latency measured on digit 5
        expect_frame(1'b0, 3'b011, 3'b110, 3'b001, 1'b1);
        scan(SB, S3, SM, S2, SB, S1);

        // Extremes: -4, 0, -4
        expect_frame(1'b0, 3'b100, 3'b000, 3'b100, 1'b0);
        scan(SM, S4, SB, S0, SM, S4);

        // Illegal segment pattern on digit 1: values held
        expect_frame(1'b1, 3'b100, 3'b000, 3'b100, 1'b0);
        scan(SB, 7'b0000000, SB, S1, SB, S1);
        check3("held_after_err", 3'b100, 3'b000, 3'b100);

        // Digit 3 glitch too short to capture -> frame never completes -> timeout
        expect_frame(1'b1, 3'b100, 3'b000, 3'b100, 1'b0);
        show(0, SB, 20); show(1, S1, 20); show(2, SB, 20);
        show(3, S2, 10);
        show(4, SB, 20); show(5, S1, 20);
        idle(300);

        // Two anodes low: no capture, no pulse
        p0 = pulses;
        an  = 8'hFC;
        seg = S1;
        repeat (50) begin
            @(posedge clk);
            #1;
        end
        idle(40);
        checks = checks + 1;
        if (pulses != p0) begin
            errors = errors + 1;
            $display("FAIL multi_anode: got %0d pulses, required 0", pulses - p0);
        end

        // Reset mid-frame after 4 digits
        show(0, SM, 20); show(1, S1, 20); show(2, SB, 20); show(3, S2, 20);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check3("mid_reset_values", 3'b000, 3'b000, 3'b000);
        check_pulses_low("mid_reset_pulses");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(5);
        check3("after_mid_reset", 3'b000, 3'b000, 3'b000);

        // -1, +2, -3
        expect_frame(1'b0, 3'b111, 3'b010, 3'b101, 1'b0);
        scan(SM, S1, SB, S2, SM, S3);
        check3("final_values", 3'b111, 3'b010, 3'b101);

        idle(300);
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL missing_pulses: %0d expected pulses never seen, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Receive-side monitor for the multiplexed 8-digit, 7-segment display bus driven by the calculator. It samples the active-low anode and segment lines, waits for each digit to hold steady, and decodes the segment patterns back into characters. It then rebuilds the three signed 3-bit operands shown on digits 0–5: A, B and result. Each complete, legal scan frame is presented as one validated word, for self-checking on hardware or in loopback simulation.

## Interface
- STABLE_CYCLES, default 16: consecutive identical samples of (digit, segments) needed before a digit is captured; legal range 2–65535.
- FRAME_TIMEOUT, default 1_000_000: clocks allowed without a capture while a frame is partly collected; legal range 2–2^24-1.
- clk  input  1  system clock; all flops rise-edge.
- rst_n  input  1  asynchronous, active-low reset.
- seg  input  7  segment lines, active-low, bit order gfedcba (bit 6 = g).
- an  input  8  anode lines, active-low; exactly one low bit selects the digit.
- a_val  output  3  last valid A, two's complement (-4..+3).
- b_val  output  3  last valid B, two's complement.
- res_val  output  3  last valid result, two's complement.
- frame_valid  output  1  one-cycle pulse when a_val/b_val/res_val update.
- frame_err  output  1  one-cycle pulse on a rejected frame or a timeout.

## Operation
- Input stage: an and seg are registered once. The registered pair drives all further logic.
- Digit select: exactly one low bit in registered an gives index 0–7. Zero or several low bits means "no digit": the dwell counter clears and no capture happens.
- Dwell counter: counts consecutive clocks with an unchanged (index, seg) pair and saturates at STABLE_CYCLES.
  - Any change to index or seg reloads the counter to 1.
  - Capture fires once, on the clock the counter reaches STABLE_CYCLES. No re-capture until the pair changes.
- Character decode of seg:
  - 1000000 = 0, 1111001 = 1, 0100100 = 2, 0110000 = 3, 0011001 = 4.
  - 0111111 = minus; 1111111 = blank.
  - Any other pattern = ILLEGAL.
- Captures on indices 6 and 7 are ignored: no state change, no timer reset.
- Collection: a capture on index 0–5 stores the 3-bit character code in slot[index] and sets mask[index]. Re-capturing a digit already in mask overwrites it (latest wins).
- Frame check, on the clock after mask becomes 6'b111111. Each pair (0,1)=A, (2,3)=B, (4,5)=result is judged as follows:
  - sign blank with magnitude 0–3 gives value = magnitude.
  - sign minus with magnitude 1–4 gives value = (0 − magnitude) mod 8, so minus-4 gives 3'b100.
  - Everything else is illegal: minus-0, blank-4, sign slot holding a digit, magnitude slot holding minus or blank, or any ILLEGAL pattern.
- Frame outcome:
  - All three pairs legal: load a_val, b_val and res_val, and pulse frame_valid.
  - Otherwise: hold the value outputs and pulse frame_err.
  - Either way, clear mask.
- Timeout: while mask is non-zero, a timer counts clocks since the last capture on index 0–5.
  - When it reaches FRAME_TIMEOUT: clear mask and pulse frame_err.
  - Any capture on index 0–5 reloads the timer. The timer is held at 0 while mask is 0.
- State machine:
  - IDLE (mask = 0) goes to COLLECT on the first capture.
  - COLLECT goes to CHECK when mask is full, and back to IDLE on timeout.
  - CHECK lasts one cycle, then goes to IDLE.
- Priority: a capture arriving in the CHECK cycle is held, then applied in IDLE on the next cycle. No capture is ever lost.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert): a_val = b_val = res_val = 0, frame_valid = 0, frame_err = 0, mask = 0, counters = 0, state IDLE. The input registers reset to an = 8'hFF and seg = 7'h7F.
- Reset asserted mid-frame discards the partial frame. No pulse is issued.
- A pair first present on the ports before edge E0 is captured at edge E0+STABLE_CYCLES.
- When that capture completes the mask, CHECK occurs at E0+STABLE_CYCLES+1, and outputs plus the pulse are registered at E0+STABLE_CYCLES+2. The pulse is high for exactly one cycle.
- frame_valid and frame_err are never high in the same cycle.
- A glitch shorter than STABLE_CYCLES restarts the dwell and produces no capture.

## Test plan
- Scan digits 0–7 showing blank,3 / minus,2 / blank,1 / blank,blank, each held 20 cycles (STABLE_CYCLES=16) -> one frame_valid; a_val=3'b011, b_val=3'b110, res_val=3'b001.
- Frame with A = minus,4, B = blank,0, result = minus,4 -> a_val=3'b100, b_val=0, res_val=3'b100.
- Digit 1 held at seg 7'b0000000 (illegal) -> frame_err pulse; values unchanged from the previous frame.
- Digit 3 shown for only 10 cycles, then the remaining digits completed -> no capture of digit 3; timeout (FRAME_TIMEOUT=200) -> frame_err and mask cleared.
- an = 8'hFC (two low) for 50 cycles -> no capture, no pulse.
- rst_n pulsed low after 4 of 6 digits are captured -> all outputs 0; the next full legal scan gives exactly one frame_valid.
